health_alarm_scheduler: RTL and testbench

- Shares one operator alarm channel (display/buzzer) among N_SRC abnormality detectors. The nervous-shock detector is one of these sources; each source drives a 2-bit severity code.
- Captures every abnormal report into a sticky per-source pending register.
- Picks the most severe pending source, breaking ties round-robin.
- Presents the winner for a minimum hold time, then waits for an operator acknowledge before serving the next source.

---
 rtl/health_alarm_scheduler_if.sv | 30 +++
 rtl/health_alarm_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_health_alarm_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/health_alarm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : health_alarm_scheduler_if
// Brief   : Detector/operator side bundle of the shared alarm channel.
// Revision: 1.0 - initial release
// ============================================================================
interface health_alarm_scheduler_if #(
    parameter int N_SRC = 4
);
    localparam int SRC_W = $clog2(N_SRC);

    logic [2*N_SRC-1:0] abnormality;
    logic               alarm_ack;
    logic               alarm_valid;
    logic [SRC_W-1:0]   alarm_src;
    logic [1:0]         alarm_level;
    logic [N_SRC-1:0]   pending_mask;
    logic               escalated;

    modport master (
        output abnormality, alarm_ack,
        input  alarm_valid, alarm_src, alarm_level, pending_mask, escalated
    );

    modport slave (
        input  abnormality, alarm_ack,
        output alarm_valid, alarm_src, alarm_level, pending_mask, escalated
    );
endinterface
`default_nettype wire

// File: rtl/health_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : health_alarm_scheduler
// Brief   : Shares one alarm channel among N_SRC detectors: sticky capture,
//           severity-first / round-robin pick, minimum hold, operator ack.
//           Optional unacked-alarm escalation under macro ALARM_ESCALATE_EN.
// Revision: 1.0 - initial release
// ============================================================================
module health_alarm_scheduler #(
    parameter int N_SRC           = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int ESCALATE_CYCLES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    health_alarm_scheduler_if.slave bus
);

    localparam int SRC_W  = $clog2(N_SRC);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [SRC_W:0]    c_N_SRC     = (SRC_W+1)'(N_SRC);
    localparam logic [HOLD_W-1:0] c_HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_SELECT   = 2'd1;
    localparam logic [1:0] c_S_SHOW     = 2'd2;
    localparam logic [1:0] c_S_WAIT_ACK = 2'd3;

    if (N_SRC < 2 || N_SRC > 8 || HOLD_CYCLES < 1 || ESCALATE_CYCLES < 1) begin : g_param_check
        $error("health_alarm_scheduler: parameter out of range");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_pend_lvl [N_SRC];
    logic [1:0]        w_pend_nxt [N_SRC];
    logic [N_SRC-1:0]  r_pending_mask;
    logic              r_alarm_valid;
    logic [SRC_W-1:0]  r_alarm_src;
    logic [1:0]        r_alarm_level;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [SRC_W-1:0]  r_rr_ptr;

    logic              w_load;
    logic              w_ack_take;
    logic              w_esc_fire;
    logic [SRC_W-1:0]  w_win_idx;
    logic [1:0]        w_win_lvl;
    logic [SRC_W:0]    w_scan;
    logic [SRC_W:0]    w_rr_sum;
    logic [SRC_W-1:0]  w_rr_nxt;
    logic [1:0]        w_abn_i;
    logic [1:0]        w_bump;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_pending_mask != '0) begin
                    w_state_nxt = c_S_SELECT;
                end
            end
            c_S_SELECT: begin
                w_load      = 1'b1;
                w_state_nxt = c_S_SHOW;
            end
            c_S_SHOW: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = c_S_WAIT_ACK;
                end
            end
            c_S_WAIT_ACK: begin
                if (bus.alarm_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Strict '>' keeps the first source in scan order on a severity tie.
    always_comb begin
        w_win_idx = r_rr_ptr;
        w_win_lvl = 2'd0;
        w_scan    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_scan >= c_N_SRC) begin
                w_scan = w_scan - c_N_SRC;
            end
            if (r_pend_lvl[w_scan[SRC_W-1:0]] > w_win_lvl) begin
                w_win_lvl = r_pend_lvl[w_scan[SRC_W-1:0]];
                w_win_idx = w_scan[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        w_rr_sum = {1'b0, r_alarm_src} + (SRC_W+1)'(1);
        w_rr_nxt = w_rr_sum[SRC_W-1:0];
        if (w_rr_sum >= c_N_SRC) begin
            w_rr_nxt = '0;
        end
    end

    // Acked source reloads from the live input so a same-cycle report survives.
    always_comb begin
        w_abn_i = 2'd0;
        w_bump  = 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            w_abn_i       = bus.abnormality[2*i +: 2];
            w_bump        = r_pend_lvl[i] + 2'd1;
            w_pend_nxt[i] = (w_abn_i > r_pend_lvl[i]) ? w_abn_i : r_pend_lvl[i];
            if (r_alarm_src == SRC_W'(i)) begin
                if (w_ack_take) begin
                    w_pend_nxt[i] = w_abn_i;
                end else if (w_esc_fire) begin
                    w_pend_nxt[i] = (w_abn_i > w_bump) ? w_abn_i : w_bump;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_pend_lvl[i] <= 2'd0;
            end
            r_pending_mask <= '0;
            r_alarm_valid  <= 1'b0;
            r_alarm_src    <= '0;
            r_alarm_level  <= 2'd0;
            r_hold_cnt     <= '0;
            r_rr_ptr       <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                r_pend_lvl[i]     <= w_pend_nxt[i];
                r_pending_mask[i] <= (w_pend_nxt[i] != 2'd0);
            end

            if (w_load) begin
                r_alarm_src   <= w_win_idx;
                r_alarm_level <= w_win_lvl;
                r_hold_cnt    <= c_HOLD_LOAD;
                r_alarm_valid <= 1'b1;
            end else if (r_state == c_S_SHOW && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            end

            if (w_ack_take) begin
                r_alarm_valid <= 1'b0;
                r_rr_ptr      <= w_rr_nxt;
            end else if (r_state == c_S_WAIT_ACK) begin
                r_alarm_level <= w_pend_nxt[r_alarm_src];
            end
        end
    end

`ifdef ALARM_ESCALATE_EN
    localparam int               ESC_W      = (ESCALATE_CYCLES > 1) ? $clog2(ESCALATE_CYCLES) : 1;
    localparam logic [ESC_W-1:0] c_ESC_LAST = ESC_W'(ESCALATE_CYCLES - 1);

    logic [ESC_W-1:0] r_esc_cnt;
    logic             r_escalated;
    logic             w_esc_due;

    assign w_esc_due  = (r_state == c_S_WAIT_ACK) && !bus.alarm_ack && (r_esc_cnt == c_ESC_LAST);
    // A level-3 alarm keeps its counter cycling but never bumps or pulses.
    assign w_esc_fire = w_esc_due && (r_pend_lvl[r_alarm_src] != 2'd3);

    always_ff @(posedge clock) begin
        if (reset || w_load || w_ack_take) begin
            r_esc_cnt <= '0;
        end else if (r_state == c_S_WAIT_ACK) begin
            r_esc_cnt <= w_esc_due ? '0 : r_esc_cnt + ESC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_escalated <= 1'b0;
        end else begin
            r_escalated <= w_esc_fire;
        end
    end

    assign bus.escalated = r_escalated;
`else
    assign w_esc_fire    = 1'b0;
    assign bus.escalated = 1'b0;
`endif

    assign bus.alarm_valid  = r_alarm_valid;
    assign bus.alarm_src    = r_alarm_src;
    assign bus.alarm_level  = r_alarm_level;
    assign bus.pending_mask = r_pending_mask;

endmodule
`default_nettype wire

// File: tb/tb_health_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_health_alarm_scheduler
// Brief   : Directed vector table plus escalation sequence for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_health_alarm_scheduler;

`ifdef ALARM_ESCALATE_EN
    localparam bit c_ESC_ON = 1'b1;
`else
    localparam bit c_ESC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    health_alarm_scheduler_if #(.N_SRC(4)) bus ();

    health_alarm_scheduler #(
        .N_SRC          (4),
        .HOLD_CYCLES    (4),
        .ESCALATE_CYCLES(8)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] abn;
        logic       ack;
        logic       care;
        logic       vld;
        logic [1:0] src;
        logic [1:0] lvl;
        logic [3:0] mask;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic [7:0] a, input logic k, input logic c,
                       input logic v, input logic [1:0] s, input logic [1:0] l,
                       input logic [3:0] m, input int n);
        vec_t t;
        t.rst = r; t.abn = a; t.ack = k; t.care = c;
        t.vld = v; t.src = s; t.lvl = l; t.mask = m;
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    task automatic step(input logic r, input logic [7:0] a, input logic k);
        rst             = r;
        bus.abnormality = a;
        bus.alarm_ack   = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic c, input logic v, input logic [1:0] s,
                         input logic [1:0] l, input logic [3:0] m, input logic e);
        n_vec++;
        if (bus.alarm_valid !== v || bus.pending_mask !== m || bus.escalated !== e ||
            (c && (bus.alarm_src !== s || bus.alarm_level !== l))) begin
            n_bad++;
            $display("FAIL %s: got valid=%0d src=%0d level=%0d mask=%b esc=%0d, want valid=%0d src=%0d level=%0d mask=%b esc=%0d%s",
                     name, bus.alarm_valid, bus.alarm_src, bus.alarm_level, bus.pending_mask,
                     bus.escalated, v, s, l, m, e, c ? "" : " (src/level not checked)");
        end
    endtask

    initial begin
        logic [1:0] exp_lvl;
        logic       exp_esc;

        rst             = 1'b1;
        bus.abnormality = '0;
        bus.alarm_ack   = 1'b0;

        //   rst abn    ack care vld src lvl mask     n
        add(1, 8'h00, 0, 1, 0, 0, 0, 4'b0000, 1);   // reset state
        // single source 0 at level 2, ack in SHOW ignored
        add(0, 8'h02, 0, 0, 0, 0, 0, 4'b0001, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b0001, 1);
        add(0, 8'h00, 0, 1, 1, 0, 2, 4'b0001, 1);
        add(0, 8'h00, 1, 1, 1, 0, 2, 4'b0001, 1);
        add(0, 8'h00, 0, 1, 1, 0, 2, 4'b0001, 3);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4'b0000, 1);
        // rr_ptr=1: sources 0 and 2 tie at level 2, level-held ack
        add(0, 8'h22, 0, 0, 0, 0, 0, 4'b0101, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b0101, 1);
        add(0, 8'h00, 0, 1, 1, 2, 2, 4'b0101, 1);
        add(0, 8'h00, 1, 1, 1, 2, 2, 4'b0101, 4);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4'b0001, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4'b0001, 1);
        add(0, 8'h00, 1, 1, 1, 0, 2, 4'b0001, 5);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4'b0000, 1);
        // source 1 level 1 and source 3 level 3 together
        add(0, 8'hC4, 0, 0, 0, 0, 0, 4'b1010, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b1010, 1);
        add(0, 8'h00, 0, 1, 1, 3, 3, 4'b1010, 5);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4'b0010, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b0010, 1);
        add(0, 8'h00, 0, 1, 1, 1, 1, 4'b0010, 5);
        // source 1 re-reports in its ack cycle
        add(0, 8'h04, 1, 0, 0, 0, 0, 4'b0010, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 4'b0010, 1);
        add(0, 8'h00, 0, 1, 1, 1, 1, 4'b0010, 5);
        // in WAIT_ACK: source 1 rises to 2 (level tracks), source 2 joins
        add(0, 8'h18, 0, 1, 1, 1, 2, 4'b0110, 1);
        // reset drops the alarm with no ack
        add(1, 8'h00, 0, 1, 0, 0, 0, 4'b0000, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 4'b0000, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].abn, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].care, vecs[i].vld, vecs[i].src,
                  vecs[i].lvl, vecs[i].mask, 1'b0);
        end

        // unacked level-1 alarm on source 0
        step(1'b1, 8'h00, 1'b0);
        check("esc_reset", 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0);
        step(1'b0, 8'h01, 1'b0);
        check("esc_capture", 1'b0, 1'b0, 2'd0, 2'd0, 4'b0001, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("esc_select", 1'b0, 1'b0, 2'd0, 2'd0, 4'b0001, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("esc_shown", 1'b1, 1'b1, 2'd0, 2'd1, 4'b0001, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            step(1'b0, 8'h00, 1'b0);
            check($sformatf("esc_show%0d", j), 1'b1, 1'b1, 2'd0, 2'd1, 4'b0001, 1'b0);
        end
        for (int j = 1; j <= 24; j++) begin
            step(1'b0, 8'h00, 1'b0);
            exp_lvl = !c_ESC_ON ? 2'd1 : (j >= 16) ? 2'd3 : (j >= 8) ? 2'd2 : 2'd1;
            exp_esc = c_ESC_ON && (j == 8 || j == 16);
            check($sformatf("esc_wait%0d", j), 1'b1, 1'b1, 2'd0, exp_lvl, 4'b0001, exp_esc);
        end
        step(1'b0, 8'h00, 1'b1);
        check("esc_ack", 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("esc_idle", 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
